spi_dev_proto: RTL and testbench
================================

Name: spi_dev_proto

Overview:
- Protocol framing stage that sits directly downstream of the SPI slave core (spi_fast_core), in the core's `clk` domain.
- RX side: splits each chip-select transaction into a command byte followed by data bytes, and reports the end of the transaction with a data-byte count.
- TX side: a small response FIFO feeds the core's byte-wide TX input, with a fill byte whenever the FIFO is empty.

Parameters:
- RESP_AW, 2: log2 of response FIFO depth (depth = 4).
- FILL_BYTE, 8'hFF: byte returned to the core when the response FIFO is empty.

Ports:
- clk  in  1  system clock, same clock as the SPI core.
- rst_n  in  1  asynchronous, active-low reset.
- spi_rx_data  in  8  received byte (core user_out).
- spi_rx_stb  in  1  one-cycle strobe, spi_rx_data valid (core user_out_stb).
- spi_tx_data  out  8  next byte to shift out (core user_in).
- spi_tx_ack  in  1  core consumed spi_tx_data (core user_in_ack).
- spi_csn_state  in  1  chip select level, 1 = deselected.
- spi_csn_fall  in  1  one-cycle pulse at transaction start.
- spi_csn_rise  in  1  one-cycle pulse at transaction end.
- pw_wdata  out  8  received byte.
- pw_wcmd  out  1  qualifies pw_wstb: byte is the command byte.
- pw_wstb  out  1  one-cycle strobe, pw_wdata/pw_wcmd valid.
- pw_end  out  1  one-cycle pulse: transaction ended.
- pw_len  out  8  data bytes (command excluded) in the transaction; saturates at 255; valid while pw_end = 1.
- pw_rdata  in  8  response byte to queue.
- pw_rstb  in  1  push pw_rdata into the response FIFO.
- pw_rfull  out  1  response FIFO full.

Behaviour:
- Reset (rst_n low, asynchronous): state = IDLE; FIFO empty; pw_wdata = 0, pw_wcmd = 0, pw_wstb = 0, pw_end = 0, pw_len = 0, pw_rfull = 0, spi_tx_data = FILL_BYTE. All outputs are registered, except spi_tx_data, which is a combinational mux from FIFO storage/pointers.
- FSM states:
  - IDLE → CMD on spi_csn_fall.
  - CMD → DATA on spi_rx_stb.
  - CMD or DATA → IDLE on spi_csn_rise.
  - CMD or DATA → CMD on spi_csn_fall (missed rise: restart framing, no pw_end, pw_len counter cleared, FIFO not flushed).
  - spi_rx_stb in IDLE is ignored (no pw_wstb).
- Counter clear: the pw_len counter clears on every spi_csn_fall.
- RX latency: spi_rx_stb at cycle N → pw_wstb = 1 at N+1 with pw_wdata = that byte.
  - pw_wcmd = 1 only if the state was CMD at N.
  - In DATA, each byte increments the pw_len counter, saturating at 255 (no wrap).
- Transaction end: spi_csn_rise at N → pw_end = 1 at N+1, pw_len = final count.
  - If spi_rx_stb coincides with spi_csn_rise at N, that byte is emitted at N+1 alongside pw_end and is included in pw_len (or is the command byte if the state was CMD).
  - Rise with zero bytes: pw_end with pw_len = 0.
  - Rise with only a command byte: pw_end with pw_len = 0.
- Response FIFO: 2^RESP_AW entries; read/write pointers are RESP_AW+1 bits wide (extra wrap bit).
  - Push: pw_rstb while not full writes pw_rdata. Push while full is dropped silently.
  - Pop: spi_tx_ack while not empty advances the read pointer. spi_tx_ack while empty is ignored (the core received FILL_BYTE).
  - spi_tx_data = head entry when not empty, FILL_BYTE when empty; updates the cycle after a pop or after a push into an empty FIFO.
  - Simultaneous push and pop:
    - Full: both take effect, level unchanged, pw_rfull stays 1.
    - Empty: push only, pop ignored.
  - pw_rfull is registered and reflects the level after this cycle's push/pop.
- Flush: spi_csn_rise empties the FIFO. Flush wins over a push or pop in the same cycle; that pushed byte is lost. Pushes while IDLE are accepted, so responses can be preloaded for the next transaction.
- spi_csn_state is used only to force IDLE if it is high while the FSM is in CMD or DATA for a full cycle without a rise pulse (glitch recovery); pw_end is still emitted in that case.

Test Plan:
- Reset → all outputs at reset values, spi_tx_data = 8'hFF.
- Transaction {fall, 0x9A, 0x11, 0x22, rise} → three pw_wstb pulses: (0x9A, cmd = 1), (0x11, cmd = 0), (0x22, cmd = 0); then pw_end with pw_len = 2.
- Preload 0xC1, 0xC2 in IDLE, then fall and three spi_tx_ack pulses → spi_tx_data sequence 0xC1, 0xC2, 0xFF; FIFO empty, pw_rfull = 0.
- Push 5 bytes 0x01..0x05 (depth 4) → pw_rfull = 1 after the 4th push, 0x05 dropped; pops yield 0x01..0x04, then 0xFF.
- spi_rx_stb (0x33) and spi_csn_rise in the same cycle after command 0x40 → pw_wstb (0x33, cmd = 0) and pw_end with pw_len = 1 in the same cycle. Also push and rise in the same cycle → FIFO empty afterwards.
- 300 data bytes after a command → pw_len = 255 (saturated). A second spi_csn_fall mid-transaction → next byte has pw_wcmd = 1 and no pw_end was emitted.

Source files
------------

// File: rtl/spi_dev_proto_if.sv
// Bus bundle between the SPI slave core, the protocol framing stage and the
// protocol user. The slave modport is the framing stage; the master modport is
// whatever drives it (core side plus user side).
interface spi_dev_proto_if;
  logic [7:0] spi_rx_data;
  logic       spi_rx_stb;
  logic [7:0] spi_tx_data;
  logic       spi_tx_ack;
  logic       spi_csn_state;
  logic       spi_csn_fall;
  logic       spi_csn_rise;
  logic [7:0] pw_wdata;
  logic       pw_wcmd;
  logic       pw_wstb;
  logic       pw_end;
  logic [7:0] pw_len;
  logic [7:0] pw_rdata;
  logic       pw_rstb;
  logic       pw_rfull;

  modport slave (
    input  spi_rx_data, spi_rx_stb, spi_tx_ack,
    input  spi_csn_state, spi_csn_fall, spi_csn_rise,
    input  pw_rdata, pw_rstb,
    output spi_tx_data,
    output pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_len, pw_rfull
  );

  modport master (
    output spi_rx_data, spi_rx_stb, spi_tx_ack,
    output spi_csn_state, spi_csn_fall, spi_csn_rise,
    output pw_rdata, pw_rstb,
    input  spi_tx_data,
    input  pw_wdata, pw_wcmd, pw_wstb, pw_end, pw_len, pw_rfull
  );
endinterface

// File: rtl/spi_dev_proto.sv
// SPI protocol framing stage. Splits each chip-select transaction into a
// command byte plus data bytes, reports transaction end with a saturating
// data-byte count, and feeds the core's TX input from a small response FIFO
// (fill byte when the FIFO is empty). Lives in the SPI core clock domain.
module spi_dev_proto #(
  parameter int         RESP_AW   = 2,
  parameter logic [7:0] FILL_BYTE = 8'hFF
) (
  input logic            clk,
  input logic            rst_n,
  spi_dev_proto_if.slave bus
);

  localparam int               DEPTH   = 1 << RESP_AW;
  localparam logic [RESP_AW:0] PTR_ONE = (RESP_AW + 1)'(1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMD  = 2'd1,
    ST_DATA = 2'd2
  } state_t;

  // Pointers carry an extra wrap bit: equal low bits with differing wrap bits
  // means the FIFO is full.
  function automatic logic ptr_full(input logic [RESP_AW:0] wp,
                                    input logic [RESP_AW:0] rp);
    return (wp[RESP_AW] != rp[RESP_AW]) &&
           (wp[RESP_AW-1:0] == rp[RESP_AW-1:0]);
  endfunction

  state_t           state_r, state_nx_s;
  logic [7:0]       wdata_r, wdata_nx_s;
  logic             wcmd_r, wcmd_nx_s;
  logic             wstb_r, wstb_nx_s;
  logic             end_r, end_nx_s;
  logic [7:0]       len_r, len_nx_s;

  logic [7:0]       mem_r [DEPTH];
  logic [RESP_AW:0] wr_ptr_r, wr_ptr_nx_s;
  logic [RESP_AW:0] rd_ptr_r, rd_ptr_nx_s;
  logic             rfull_r, rfull_nx_s;
  logic             empty_s, full_s, push_s, pop_s, flush_s;

  // Framing FSM: next state, write strobe and byte counter
  always_comb begin
    state_nx_s = state_r;
    wdata_nx_s = wdata_r;
    wcmd_nx_s  = 1'b0;
    wstb_nx_s  = 1'b0;
    end_nx_s   = 1'b0;
    len_nx_s   = len_r;
    case (state_r)
      ST_IDLE: begin
        if (bus.spi_csn_fall) begin
          state_nx_s = ST_CMD;
          len_nx_s   = 8'd0;
        end else begin
          state_nx_s = ST_IDLE;
        end
      end
      ST_CMD: begin
        if (bus.spi_csn_fall) begin
          // Missed rise: restart framing without reporting an end.
          state_nx_s = ST_CMD;
          len_nx_s   = 8'd0;
        end else begin
          if (bus.spi_rx_stb) begin
            state_nx_s = ST_DATA;
            wdata_nx_s = bus.spi_rx_data;
            wcmd_nx_s  = 1'b1;
            wstb_nx_s  = 1'b1;
          end else begin
            state_nx_s = ST_CMD;
          end
          // A deselected chip select without a rise pulse is treated as a rise.
          if (bus.spi_csn_rise || bus.spi_csn_state) begin
            state_nx_s = ST_IDLE;
            end_nx_s   = 1'b1;
          end else begin
            end_nx_s   = 1'b0;
          end
        end
      end
      ST_DATA: begin
        if (bus.spi_csn_fall) begin
          state_nx_s = ST_CMD;
          len_nx_s   = 8'd0;
        end else begin
          if (bus.spi_rx_stb) begin
            wdata_nx_s = bus.spi_rx_data;
            wstb_nx_s  = 1'b1;
            if (len_r != 8'hFF) begin
              len_nx_s = len_r + 8'd1;
            end else begin
              len_nx_s = len_r;
            end
          end else begin
            len_nx_s = len_r;
          end
          if (bus.spi_csn_rise || bus.spi_csn_state) begin
            state_nx_s = ST_IDLE;
            end_nx_s   = 1'b1;
          end else begin
            state_nx_s = ST_DATA;
          end
        end
      end
      default: begin
        state_nx_s = ST_IDLE;
        len_nx_s   = 8'd0;
      end
    endcase
  end

  // Framing FSM state and registered write-side outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= ST_IDLE;
      wdata_r <= 8'd0;
      wcmd_r  <= 1'b0;
      wstb_r  <= 1'b0;
      end_r   <= 1'b0;
      len_r   <= 8'd0;
    end else begin
      state_r <= state_nx_s;
      wdata_r <= wdata_nx_s;
      wcmd_r  <= wcmd_nx_s;
      wstb_r  <= wstb_nx_s;
      end_r   <= end_nx_s;
      len_r   <= len_nx_s;
    end
  end

  assign empty_s = (wr_ptr_r == rd_ptr_r);
  assign full_s  = ptr_full(wr_ptr_r, rd_ptr_r);
  assign flush_s = bus.spi_csn_rise;
  assign pop_s   = bus.spi_tx_ack && !empty_s;
  // A pop in the same cycle frees the slot, so a push into a full FIFO lands.
  assign push_s  = bus.pw_rstb && (!full_s || pop_s);

  // Response FIFO pointer update; a flush overrides push and pop
  always_comb begin
    wr_ptr_nx_s = wr_ptr_r;
    rd_ptr_nx_s = rd_ptr_r;
    if (flush_s) begin
      wr_ptr_nx_s = '0;
      rd_ptr_nx_s = '0;
    end else begin
      if (push_s) begin
        wr_ptr_nx_s = wr_ptr_r + PTR_ONE;
      end else begin
        wr_ptr_nx_s = wr_ptr_r;
      end
      if (pop_s) begin
        rd_ptr_nx_s = rd_ptr_r + PTR_ONE;
      end else begin
        rd_ptr_nx_s = rd_ptr_r;
      end
    end
    rfull_nx_s = ptr_full(wr_ptr_nx_s, rd_ptr_nx_s);
  end

  // Response FIFO pointers and registered full flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= '0;
      rd_ptr_r <= '0;
      rfull_r  <= 1'b0;
    end else begin
      wr_ptr_r <= wr_ptr_nx_s;
      rd_ptr_r <= rd_ptr_nx_s;
      rfull_r  <= rfull_nx_s;
    end
  end

  // Response FIFO storage; contents are don't-care until written
  always_ff @(posedge clk) begin
    if (push_s && !flush_s) begin
      mem_r[wr_ptr_r[RESP_AW-1:0]] <= bus.pw_rdata;
    end
  end

  assign bus.spi_tx_data = empty_s ? FILL_BYTE : mem_r[rd_ptr_r[RESP_AW-1:0]];
  assign bus.pw_wdata    = wdata_r;
  assign bus.pw_wcmd     = wcmd_r;
  assign bus.pw_wstb     = wstb_r;
  assign bus.pw_end      = end_r;
  assign bus.pw_len      = len_r;
  assign bus.pw_rfull    = rfull_r;

endmodule

// File: tb/tb_spi_dev_proto.sv
// Directed self-checking bench for spi_dev_proto: framing, byte count
// saturation, restart on a missed rise, chip-select glitch recovery and the
// response FIFO (preload, overflow, concurrent push/pop, flush).
module tb_spi_dev_proto;

  logic clk;
  logic rst_n;
  int   n_chk;
  int   n_pass;

  spi_dev_proto_if bus ();

  spi_dev_proto #(
    .RESP_AW  (2),
    .FILL_BYTE(8'hFF)
  ) u_dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) begin
      n_pass++;
    end else begin
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One clock cycle with the given pulses; outputs are sampled 1 ns after the edge.
  task automatic cyc(input logic fall, input logic rise, input logic stb,
                     input logic [7:0] rx, input logic ack, input logic rstb,
                     input logic [7:0] rd);
    bus.spi_csn_fall = fall;
    bus.spi_csn_rise = rise;
    bus.spi_rx_stb   = stb;
    bus.spi_rx_data  = rx;
    bus.spi_tx_ack   = ack;
    bus.pw_rstb      = rstb;
    bus.pw_rdata     = rd;
    if (fall) bus.spi_csn_state = 1'b0;
    else if (rise) bus.spi_csn_state = 1'b1;
    @(posedge clk);
    #1;
    bus.spi_csn_fall = 1'b0;
    bus.spi_csn_rise = 1'b0;
    bus.spi_rx_stb   = 1'b0;
    bus.spi_tx_ack   = 1'b0;
    bus.pw_rstb      = 1'b0;
  endtask

  task automatic t_idle();            cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00); endtask
  task automatic t_fall();            cyc(1'b1, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00); endtask
  task automatic t_rise();            cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00); endtask
  task automatic t_rx(input logic [7:0] b);   cyc(1'b0, 1'b0, 1'b1, b, 1'b0, 1'b0, 8'h00); endtask
  task automatic t_push(input logic [7:0] b); cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b1, b); endtask
  task automatic t_pop();             cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00); endtask

  initial begin
    n_chk  = 0;
    n_pass = 0;
    rst_n  = 1'b0;
    bus.spi_rx_data   = 8'h00;
    bus.spi_rx_stb    = 1'b0;
    bus.spi_tx_ack    = 1'b0;
    bus.spi_csn_state = 1'b1;
    bus.spi_csn_fall  = 1'b0;
    bus.spi_csn_rise  = 1'b0;
    bus.pw_rdata      = 8'h00;
    bus.pw_rstb       = 1'b0;

    // Reset values
    #12;
    chk("rst_tx", bus.spi_tx_data, 8'hFF);
    chk("rst_wdata", bus.pw_wdata, 8'h00);
    chk("rst_wcmd", bus.pw_wcmd, 1'b0);
    chk("rst_wstb", bus.pw_wstb, 1'b0);
    chk("rst_end", bus.pw_end, 1'b0);
    chk("rst_len", bus.pw_len, 8'h00);
    chk("rst_rfull", bus.pw_rfull, 1'b0);
    #10;
    rst_n = 1'b1;
    t_idle();

    // Basic transaction: command plus two data bytes
    t_fall();
    chk("t1_fall_wstb", bus.pw_wstb, 1'b0);
    t_rx(8'h9A);
    chk("t1_b0_stb", bus.pw_wstb, 1'b1);
    chk("t1_b0_data", bus.pw_wdata, 8'h9A);
    chk("t1_b0_cmd", bus.pw_wcmd, 1'b1);
    t_rx(8'h11);
    chk("t1_b1_stb", bus.pw_wstb, 1'b1);
    chk("t1_b1_data", bus.pw_wdata, 8'h11);
    chk("t1_b1_cmd", bus.pw_wcmd, 1'b0);
    t_rx(8'h22);
    chk("t1_b2_data", bus.pw_wdata, 8'h22);
    chk("t1_b2_cmd", bus.pw_wcmd, 1'b0);
    chk("t1_b2_end", bus.pw_end, 1'b0);
    t_rise();
    chk("t1_end", bus.pw_end, 1'b1);
    chk("t1_len", bus.pw_len, 8'd2);
    chk("t1_end_wstb", bus.pw_wstb, 1'b0);
    t_idle();
    chk("t1_end_pulse", bus.pw_end, 1'b0);

    // Preloaded responses, then fill byte once drained
    t_push(8'hC1);
    chk("t2_tx_after_push", bus.spi_tx_data, 8'hC1);
    t_push(8'hC2);
    t_fall();
    chk("t2_tx0", bus.spi_tx_data, 8'hC1);
    t_pop();
    chk("t2_tx1", bus.spi_tx_data, 8'hC2);
    t_pop();
    chk("t2_tx2", bus.spi_tx_data, 8'hFF);
    t_pop();
    chk("t2_tx_empty_ack", bus.spi_tx_data, 8'hFF);
    chk("t2_rfull", bus.pw_rfull, 1'b0);
    t_rise();
    chk("t2_end_zero", bus.pw_end, 1'b1);
    chk("t2_len_zero", bus.pw_len, 8'd0);

    // Overflow: fifth push dropped
    for (int i = 1; i <= 5; i++) begin
      t_push(8'(i));
      chk($sformatf("t3_rfull_%0d", i), bus.pw_rfull, (i >= 4) ? 1'b1 : 1'b0);
    end
    chk("t3_head", bus.spi_tx_data, 8'h01);
    for (int i = 2; i <= 4; i++) begin
      t_pop();
      chk($sformatf("t3_pop_%0d", i), bus.spi_tx_data, 8'(i));
      chk($sformatf("t3_pop_rfull_%0d", i), bus.pw_rfull, 1'b0);
    end
    t_pop();
    chk("t3_drained", bus.spi_tx_data, 8'hFF);

    // Concurrent push and pop while full, then while empty
    for (int i = 0; i < 4; i++) t_push(8'hA0 + 8'(i));
    chk("t4_full", bus.pw_rfull, 1'b1);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hA4);
    chk("t4_full_pp_rfull", bus.pw_rfull, 1'b1);
    chk("t4_full_pp_head", bus.spi_tx_data, 8'hA1);
    for (int i = 2; i <= 4; i++) begin
      t_pop();
      chk($sformatf("t4_pop_%0d", i), bus.spi_tx_data, 8'hA0 + 8'(i));
    end
    t_pop();
    chk("t4_drained", bus.spi_tx_data, 8'hFF);
    cyc(1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 1'b1, 8'hB0);
    chk("t4_empty_pp_head", bus.spi_tx_data, 8'hB0);
    t_pop();
    chk("t4_empty_pp_drain", bus.spi_tx_data, 8'hFF);

    // Byte coinciding with rise; push coinciding with rise
    t_fall();
    t_rx(8'h40);
    chk("t5_cmd", bus.pw_wcmd, 1'b1);
    cyc(1'b0, 1'b1, 1'b1, 8'h33, 1'b0, 1'b0, 8'h00);
    chk("t5_stb", bus.pw_wstb, 1'b1);
    chk("t5_data", bus.pw_wdata, 8'h33);
    chk("t5_wcmd", bus.pw_wcmd, 1'b0);
    chk("t5_end", bus.pw_end, 1'b1);
    chk("t5_len", bus.pw_len, 8'd1);
    t_fall();
    t_push(8'h77);
    chk("t5_tx_push", bus.spi_tx_data, 8'h77);
    t_rx(8'h50);
    cyc(1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 8'h78);
    chk("t5_cmdonly_end", bus.pw_end, 1'b1);
    chk("t5_cmdonly_len", bus.pw_len, 8'd0);
    chk("t5_flush_tx", bus.spi_tx_data, 8'hFF);
    chk("t5_flush_rfull", bus.pw_rfull, 1'b0);
    t_idle();
    chk("t5_flush_tx2", bus.spi_tx_data, 8'hFF);

    // Count saturation
    t_fall();
    t_rx(8'h01);
    for (int i = 0; i < 300; i++) t_rx(8'(i));
    t_rise();
    chk("t6_sat_end", bus.pw_end, 1'b1);
    chk("t6_sat_len", bus.pw_len, 8'd255);

    // Missed rise: second fall restarts framing
    t_fall();
    t_rx(8'hA5);
    t_rx(8'h10);
    t_rx(8'h11);
    t_fall();
    chk("t7_refall_end", bus.pw_end, 1'b0);
    chk("t7_refall_wstb", bus.pw_wstb, 1'b0);
    t_rx(8'h22);
    chk("t7_recmd_stb", bus.pw_wstb, 1'b1);
    chk("t7_recmd_cmd", bus.pw_wcmd, 1'b1);
    chk("t7_recmd_end", bus.pw_end, 1'b0);
    t_rise();
    chk("t7_end", bus.pw_end, 1'b1);
    chk("t7_len", bus.pw_len, 8'd0);

    // Chip select deasserted without a rise pulse
    t_fall();
    t_rx(8'h60);
    t_rx(8'h61);
    bus.spi_csn_state = 1'b1;
    t_idle();
    chk("t8_glitch_end", bus.pw_end, 1'b1);
    chk("t8_glitch_len", bus.pw_len, 8'd1);
    t_rx(8'h62);
    chk("t8_idle_stb", bus.pw_wstb, 1'b0);
    chk("t8_idle_end", bus.pw_end, 1'b0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
